// File: rtl/decode_pkg.sv
// RV32I decode definitions: opcodes, ALU op codes, immediate formats, decoded bundle.
// Shared by the combinational decoder and the registered stage.
package decode_pkg;

    localparam int XLEN_C   = 32;
    localparam int REG_W    = 5;
    localparam int ALU_OP_W = 5;
    localparam int SIZE_W   = 3;

    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_OP     = 7'h33;

    localparam logic [6:0] F7_BASE   = 7'h00;
    localparam logic [6:0] F7_ALT    = 7'h20;
    localparam logic [6:0] F7_MULDIV = 7'h01;

    localparam logic [ALU_OP_W-1:0] ALU_OP_ADD = 5'h00;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SUB = 5'h08;

    typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} skid_st_e;

    typedef struct packed {
        logic [XLEN_C-1:0]   imm;
        logic [ALU_OP_W-1:0] alu_op;
        logic [REG_W-1:0]    ra;
        logic [REG_W-1:0]    rb;
        logic [REG_W-1:0]    rd;
        logic                sel_imm_b;
        logic                sel_pc_a;
        logic                wb;
        logic                mem_rd;
        logic                mem_wr;
        logic [SIZE_W-1:0]   mem_size;
        logic                branch;
        logic                jump;
        logic [2:0]          cmp;
        logic                illegal;
    } dec_t;

    function automatic logic [XLEN_C-1:0] make_imm(input imm_fmt_e fmt, input logic [31:0] i);
        logic [XLEN_C-1:0] r;
        case (fmt)
            IMM_I:   r = {{20{i[31]}}, i[31:20]};
            IMM_S:   r = {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_B:   r = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            IMM_U:   r = {i[31:12], 12'b0};
            IMM_J:   r = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/decode_comb.sv
// Purely combinational RV32I(+M) instruction-to-bundle decoder; zero latency.
// No flow control; illegal encodings yield an all-zero bundle with only illegal set.
module decode_comb
    import decode_pkg::*;
#(
    parameter bit ENABLE_M = 1'b0
) (
    input  logic [31:0] instr,
    output dec_t        dec
);

    logic [6:0]       opc;
    logic [6:0]       f7;
    logic [2:0]       f3;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rdf;
    logic             legal;
    imm_fmt_e         fmt;
    dec_t             d;

    assign opc = instr[6:0];
    assign f3  = instr[14:12];
    assign f7  = instr[31:25];
    assign rs1 = instr[19:15];
    assign rs2 = instr[24:20];
    assign rdf = instr[11:7];

    always_comb begin
        d     = '0;
        fmt   = IMM_NONE;
        legal = 1'b1;
        case (opc)
            OPC_LUI: begin
                fmt = IMM_U; d.rd = rdf; d.sel_imm_b = 1'b1; d.wb = 1'b1;
            end
            OPC_AUIPC: begin
                fmt = IMM_U; d.rd = rdf; d.sel_imm_b = 1'b1; d.sel_pc_a = 1'b1; d.wb = 1'b1;
            end
            OPC_JAL: begin
                fmt = IMM_J; d.rd = rdf; d.sel_imm_b = 1'b1; d.sel_pc_a = 1'b1;
                d.jump = 1'b1; d.wb = 1'b1;
            end
            OPC_JALR: begin
                legal = (f3 == 3'd0);
                fmt = IMM_I; d.ra = rs1; d.rd = rdf; d.sel_imm_b = 1'b1;
                d.jump = 1'b1; d.wb = 1'b1;
            end
            OPC_BRANCH: begin
                legal = (f3 != 3'd2) && (f3 != 3'd3);
                fmt = IMM_B; d.ra = rs1; d.rb = rs2; d.branch = 1'b1; d.cmp = f3;
            end
            OPC_LOAD: begin
                legal = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
                fmt = IMM_I; d.ra = rs1; d.rd = rdf; d.sel_imm_b = 1'b1;
                d.mem_rd = 1'b1; d.mem_size = f3; d.wb = 1'b1;
            end
            OPC_STORE: begin
                legal = (f3 <= 3'd2);
                fmt = IMM_S; d.ra = rs1; d.rb = rs2; d.sel_imm_b = 1'b1;
                d.mem_wr = 1'b1; d.mem_size = f3;
            end
            OPC_OP_IMM: begin
                fmt = IMM_I; d.ra = rs1; d.rd = rdf; d.sel_imm_b = 1'b1; d.wb = 1'b1;
                d.alu_op = {2'b00, f3};
                // Only the shift-immediates carry meaning in funct7.
                if (f3 == 3'b001) begin
                    legal = (f7 == F7_BASE);
                end else if (f3 == 3'b101) begin
                    legal       = (f7 == F7_BASE) || (f7 == F7_ALT);
                    d.alu_op[3] = (f7 == F7_ALT);
                end
            end
            OPC_OP: begin
                d.ra = rs1; d.rb = rs2; d.rd = rdf; d.wb = 1'b1;
                case (f7)
                    F7_BASE:   d.alu_op = {2'b00, f3};
                    F7_ALT: begin
                        legal    = (f3 == 3'b000) || (f3 == 3'b101);
                        d.alu_op = {2'b01, f3};
                    end
                    F7_MULDIV: begin
                        legal    = ENABLE_M;
                        d.alu_op = {2'b10, f3};
                    end
                    default:   legal = 1'b0;
                endcase
            end
            default: legal = 1'b0;
        endcase
        d.imm = make_imm(fmt, instr);
        if (d.rd == '0) begin
            d.wb = 1'b0;
        end
        if (!legal) begin
            d         = '0;
            d.illegal = 1'b1;
        end
    end

    assign dec = d;

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage with optional 2-entry skid; one-cycle latency.
// in_ready is registered (no comb path from out_ready) when SKID=1; flush empties all entries.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int PC_W     = 32,
    parameter bit ENABLE_M = 1'b0,
    parameter bit SKID     = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_alu_op,
    output logic [4:0]      out_ra,
    output logic [4:0]      out_rb,
    output logic [4:0]      out_rd,
    output logic            out_sel_imm_b,
    output logic            out_sel_pc_a,
    output logic            out_wb,
    output logic            out_mem_rd,
    output logic            out_mem_wr,
    output logic [2:0]      out_mem_size,
    output logic            out_branch,
    output logic            out_jump,
    output logic [2:0]      out_cmp,
    output logic            out_illegal
);

    if (XLEN != 32) begin : g_xlen_check
        $error("decode_stage: XLEN must be 32");
    end

    dec_t            dec;
    dec_t            out_q, skid_q;
    logic [PC_W-1:0] out_pc_q, skid_pc_q;
    skid_st_e        state_q, state_nxt;
    logic            rdy_q;
    logic            acc, pop, load_out_in, load_out_skid, load_skid;

    decode_comb #(.ENABLE_M(ENABLE_M)) u_decode_comb (
        .instr (in_instr),
        .dec   (dec)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            rdy_q   <= (state_nxt != ST_TWO);
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_EMPTY: if (acc) state_nxt = ST_ONE;
            ST_ONE: begin
                if (acc && !pop)      state_nxt = ST_TWO;
                else if (!acc && pop) state_nxt = ST_EMPTY;
            end
            ST_TWO:   if (pop) state_nxt = ST_ONE;
            default:  state_nxt = ST_EMPTY;
        endcase
        if (flush) begin
            state_nxt = ST_EMPTY;
        end
    end

    // Without the skid entry the stage degrades to a single register with a comb ready.
    always_comb begin
        out_valid     = (state_q != ST_EMPTY);
        in_ready      = rdy_q && (SKID || !out_valid || out_ready);
        acc           = in_valid && in_ready && !flush;
        pop           = out_valid && out_ready;
        load_out_in   = acc && ((state_q == ST_EMPTY) || pop);
        load_out_skid = pop && (state_q == ST_TWO);
        load_skid     = acc && (state_q == ST_ONE) && !pop;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q     <= '0;
            out_pc_q  <= '0;
            skid_q    <= '0;
            skid_pc_q <= '0;
        end else begin
            if (load_out_in) begin
                out_q    <= dec;
                out_pc_q <= in_pc;
            end else if (load_out_skid) begin
                out_q    <= skid_q;
                out_pc_q <= skid_pc_q;
            end
            if (load_skid) begin
                skid_q    <= dec;
                skid_pc_q <= in_pc;
            end
        end
    end

    assign out_pc        = out_pc_q;
    assign out_imm       = out_q.imm;
    assign out_alu_op    = out_q.alu_op;
    assign out_ra        = out_q.ra;
    assign out_rb        = out_q.rb;
    assign out_rd        = out_q.rd;
    assign out_sel_imm_b = out_q.sel_imm_b;
    assign out_sel_pc_a  = out_q.sel_pc_a;
    assign out_wb        = out_q.wb;
    assign out_mem_rd    = out_q.mem_rd;
    assign out_mem_wr    = out_q.mem_wr;
    assign out_mem_size  = out_q.mem_size;
    assign out_branch    = out_q.branch;
    assign out_jump      = out_q.jump;
    assign out_cmp       = out_q.cmp;
    assign out_illegal   = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: reference decoder plus FIFO scoreboard, and directed literal vectors.
module tb_decode_stage;

    localparam bit EN_M = 1'b0;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, out_pc, out_imm;
    logic [4:0]  out_alu_op, out_ra, out_rb, out_rd;
    logic        out_sel_imm_b, out_sel_pc_a, out_wb, out_mem_rd, out_mem_wr;
    logic [2:0]  out_mem_size, out_cmp;
    logic        out_branch, out_jump, out_illegal;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .PC_W(32), .ENABLE_M(EN_M), .SKID(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_imm(out_imm),
        .out_alu_op(out_alu_op), .out_ra(out_ra), .out_rb(out_rb), .out_rd(out_rd),
        .out_sel_imm_b(out_sel_imm_b), .out_sel_pc_a(out_sel_pc_a), .out_wb(out_wb),
        .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr), .out_mem_size(out_mem_size),
        .out_branch(out_branch), .out_jump(out_jump), .out_cmp(out_cmp), .out_illegal(out_illegal)
    );

    typedef struct packed {
        logic [31:0] imm;
        logic [4:0]  op, ra, rb, rd;
        logic        sib, spa, wb, mrd, mwr;
        logic [2:0]  msz;
        logic        br, jmp;
        logic [2:0]  cmp;
        logic        ill;
    } exp_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } beat_t;

    wire [65:0] act_vec = {out_imm, out_alu_op, out_ra, out_rb, out_rd, out_sel_imm_b,
                           out_sel_pc_a, out_wb, out_mem_rd, out_mem_wr, out_mem_size,
                           out_branch, out_jump, out_cmp, out_illegal};

    int          n_cmp = 0, n_bad = 0, n_acc = 0, n_pop = 0;
    int          cyc, base_acc, base_pop;
    bit          armed = 1'b0, rst_last = 1'b1;
    beat_t       q[$];
    logic [31:0] pc_log[$];
    exp_t        e;
    logic [31:0] prog [12] = '{32'h00500093, 32'h40208033, 32'hFE000EE3, 32'h0080006F,
                               32'h00412083, 32'h00112223, 32'h4020D093, 32'h123450B7,
                               32'h00001117, 32'h000080E7, 32'h0000007F, 32'h02208033};

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference decoder: the architectural rules, field by field.
    function automatic exp_t model(input logic [31:0] i);
        exp_t r;
        logic ok;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] iI, iS, iB, iU, iJ;
        iI = {{20{i[31]}}, i[31:20]};
        iS = {{20{i[31]}}, i[31:25], i[11:7]};
        iB = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
        iU = {i[31:12], 12'b0};
        iJ = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        f3 = i[14:12];
        f7 = i[31:25];
        r  = '0;
        ok = 1'b1;
        case (i[6:0])
            7'h37: begin r.rd = i[11:7]; r.imm = iU; r.sib = 1; r.wb = 1; end
            7'h17: begin r.rd = i[11:7]; r.imm = iU; r.sib = 1; r.spa = 1; r.wb = 1; end
            7'h6F: begin r.rd = i[11:7]; r.imm = iJ; r.sib = 1; r.spa = 1; r.jmp = 1; r.wb = 1; end
            7'h67: begin ok = (f3 == 0); r.ra = i[19:15]; r.rd = i[11:7]; r.imm = iI;
                         r.sib = 1; r.jmp = 1; r.wb = 1; end
            7'h63: begin ok = !(f3 inside {3'd2, 3'd3}); r.ra = i[19:15]; r.rb = i[24:20];
                         r.imm = iB; r.br = 1; r.cmp = f3; end
            7'h03: begin ok = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}); r.ra = i[19:15];
                         r.rd = i[11:7]; r.imm = iI; r.sib = 1; r.mrd = 1; r.msz = f3; r.wb = 1; end
            7'h23: begin ok = (f3 <= 2); r.ra = i[19:15]; r.rb = i[24:20]; r.imm = iS;
                         r.sib = 1; r.mwr = 1; r.msz = f3; end
            7'h13: begin
                r.ra = i[19:15]; r.rd = i[11:7]; r.imm = iI; r.sib = 1; r.wb = 1; r.op = 5'(f3);
                if (f3 == 1) ok = (f7 == 0);
                if (f3 == 5) begin ok = (f7 == 0) || (f7 == 7'h20); if (f7 == 7'h20) r.op = r.op + 8; end
            end
            7'h33: begin
                r.ra = i[19:15]; r.rb = i[24:20]; r.rd = i[11:7]; r.wb = 1;
                if (f7 == 0) r.op = 5'(f3);
                else if (f7 == 7'h20) begin ok = (f3 == 0) || (f3 == 5); r.op = 5'(8 + f3); end
                else if (f7 == 7'h01) begin ok = EN_M; r.op = 5'(16 + f3); end
                else ok = 1'b0;
            end
            default: ok = 1'b0;
        endcase
        if (r.rd == 0) r.wb = 0;
        if (!ok) begin r = '0; r.ill = 1; end
        return r;
    endfunction

    // Scoreboard: checks held state each cycle, then applies the handshakes of the next edge.
    always @(negedge clk) begin
        if (armed) begin
            chk("out_valid", out_valid, q.size() != 0);
            chk("in_ready", in_ready, !rst_last && q.size() < 2);
            if (out_valid && q.size() != 0) begin
                e = model(q[0].instr);
                chk("bundle", act_vec, e);
                chk("pc", out_pc, q[0].pc);
            end
            if (!rst_n || flush) begin
                q.delete();
            end else begin
                if (out_valid && out_ready) begin
                    n_pop++;
                    pc_log.push_back(out_pc);
                    if (q.size() != 0) void'(q.pop_front());
                end
                if (in_valid && in_ready) begin
                    n_acc++;
                    q.push_back('{instr: in_instr, pc: in_pc});
                end
            end
            rst_last = !rst_n;
        end
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic beat(input logic [31:0] ins, input logic [31:0] pc, inout int c);
        bit r;
        int w;
        in_valid = 1'b1; in_instr = ins; in_pc = pc; w = 0;
        do begin
            @(negedge clk); r = in_ready;
            @(posedge clk); #1; c++; w++;
        end while (!r && w < 50);
        if (!r) chk("accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic stream(input int n, input logic [31:0] pc0, inout int c);
        for (int k = 0; k < n; k++) beat(prog[k % 12], pc0 + 32'(4 * k), c);
    endtask

    task automatic one(input logic [31:0] ins, input logic [31:0] pc);
        int c = 0;
        tick;
        beat(ins, pc, c);
        @(negedge clk);
        chk("latency_valid", out_valid, 1);
        chk("latency_pc", out_pc, pc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, n_bad=%0d", n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; flush = 0; in_valid = 0; in_instr = 0; in_pc = 0; out_ready = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_bundle", act_vec, 0);
        chk("rst_pc", out_pc, 0);
        tick; rst_n = 1; armed = 1;
        tick; @(negedge clk);
        chk("ready_after_rst", in_ready, 1);
        tick; out_ready = 1;

        one(32'h00500093, 32'h1000);
        chk("addi_imm", out_imm, 5);   chk("addi_rd", out_rd, 1);  chk("addi_ra", out_ra, 0);
        chk("addi_wb", out_wb, 1);     chk("addi_sib", out_sel_imm_b, 1); chk("addi_op", out_alu_op, 0);
        one(32'h40208033, 32'h1004);
        chk("sub_op", out_alu_op, 5'h08); chk("sub_ra", out_ra, 1); chk("sub_rb", out_rb, 2);
        one(32'hFE000EE3, 32'h1008);
        chk("beq_imm", out_imm, 32'hFFFFFFFC); chk("beq_br", out_branch, 1); chk("beq_cmp", out_cmp, 0);
        one(32'h0080006F, 32'h100C);
        chk("jal_imm", out_imm, 8); chk("jal_wb", out_wb, 0); chk("jal_jump", out_jump, 1);
        chk("jal_pca", out_sel_pc_a, 1);
        one(32'h0000007F, 32'h1010);
        chk("bad_ill", out_illegal, 1); chk("bad_wb", out_wb, 0); chk("bad_mrd", out_mem_rd, 0);
        chk("bad_mwr", out_mem_wr, 0);  chk("bad_br", out_branch, 0); chk("bad_jmp", out_jump, 0);
        one(32'h02208033, 32'h1014);
        chk("mul_ill", out_illegal, 1); chk("mul_wb", out_wb, 0);
        one(32'h00412083, 32'h1018);
        chk("lw_imm", out_imm, 4); chk("lw_mrd", out_mem_rd, 1); chk("lw_size", out_mem_size, 2);
        chk("lw_ra", out_ra, 2);
        one(32'h00112223, 32'h101C);
        chk("sw_imm", out_imm, 4); chk("sw_mwr", out_mem_wr, 1); chk("sw_rd", out_rd, 0);
        chk("sw_rb", out_rb, 1);
        one(32'h4020D093, 32'h1020);
        chk("srai_op", out_alu_op, 5'h0D);
        one(32'h40209093, 32'h1024);
        chk("slli_f7_ill", out_illegal, 1);

        tick; cyc = 0;
        stream(8, 32'h2000, cyc);
        chk("throughput8", cyc, 8);

        repeat (3) tick;
        out_ready = 0; base_acc = n_acc; base_pop = n_pop; pc_log.delete();
        fork
            begin
                int c = 0;
                stream(8, 32'h3000, c);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                chk("bp_accepts", n_acc - base_acc, 2);
                chk("bp_in_ready", in_ready, 0);
                out_ready = 1;
            end
        join
        repeat (4) tick;
        chk("bp_pops", n_pop - base_pop, 8);
        for (int k = 0; k < 8; k++)
            chk("bp_order", (k < pc_log.size()) ? pc_log[k] : 32'hDEADBEEF, 32'h3000 + 32'(4 * k));

        out_ready = 0; cyc = 0;
        stream(2, 32'h4000, cyc);
        chk("fl_two_held", in_ready, 0);
        in_valid = 1; in_instr = 32'h40208033; in_pc = 32'h4008; flush = 1;
        tick; flush = 0; in_valid = 0;
        @(negedge clk);
        chk("fl_valid", out_valid, 0);
        chk("fl_ready", in_ready, 1);
        tick; out_ready = 1;
        one(32'h00500093, 32'h5000);
        chk("fl_after_imm", out_imm, 5); chk("fl_after_rd", out_rd, 1);

        tick; out_ready = 0; cyc = 0;
        stream(1, 32'h6000, cyc);
        chk("mr_held", out_valid, 1);
        rst_n = 0; in_valid = 1; in_instr = 32'h00500093; in_pc = 32'h6004;
        tick; rst_n = 1; in_valid = 0;
        @(negedge clk);
        chk("mr_valid", out_valid, 0);
        chk("mr_ready", in_ready, 0);
        chk("mr_bundle", act_vec, 0);
        chk("mr_pc", out_pc, 0);
        tick; out_ready = 1; cyc = 0;
        stream(6, 32'h7000, cyc);
        chk("mr_throughput", cyc, 6);
        repeat (3) tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
